// File: rtl/dmem_lsu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared funct3 constants, FSM state type and decode helpers for the
//            load/store sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_CAP  = 3'd2,
        RMW_RD  = 3'd3,
        RMW_MRG = 3'd4,
        WR      = 3'd5,
        RESP    = 3'd6
    } lsu_state_t;

    // Stores have no unsigned variants, so only the three width codes are legal.
    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) ||
               ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lsu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu_ctrl_if
// Purpose  : Core request/response and word-memory signals of the LSU.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_lsu_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_load;
    logic        mem_store;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_load, mem_store, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_load, mem_store, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/dmem_lsu_ctrl_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Combinational load lane extraction/extension and store merge.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  wire logic [31:0] rdata_i,
    input  wire logic [1:0]  lane_i,
    input  wire logic [2:0]  funct3_i,
    input  wire logic [15:0] new_i,
    output logic      [31:0] load_data_o,
    output logic      [31:0] merge_data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (lane_i)
            2'd0: w_byte = rdata_i[7:0];
            2'd1: w_byte = rdata_i[15:8];
            2'd2: w_byte = rdata_i[23:16];
            default: w_byte = rdata_i[31:24];
        endcase
        w_half = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_B:    load_data_o = {{24{w_byte[7]}}, w_byte};
            F3_BU:   load_data_o = {24'h000000, w_byte};
            F3_H:    load_data_o = {{16{w_half[15]}}, w_half};
            F3_HU:   load_data_o = {16'h0000, w_half};
            default: load_data_o = rdata_i;
        endcase

        // Half lane ignores addr[0] so the unchecked-alignment mode falls out naturally.
        merge_data_o = rdata_i;
        if (funct3_i[1:0] == 2'b00)
            merge_data_o[{lane_i, 3'b000} +: 8] = new_i[7:0];
        else if (funct3_i[1:0] == 2'b01)
            merge_data_o[{lane_i[1], 4'b0000} +: 16] = new_i;
    end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu_ctrl
// Purpose  : One-at-a-time RV32I load/store sequencer for a word-only memory.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu_ctrl
    import lsu_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
)(
    input  wire logic        clk,
    input  wire logic        rst,
    dmem_lsu_ctrl_if.slave   bus
);

    lsu_state_t  state_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        err_d;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign err_d = !is_legal(bus.req_we, bus.req_funct3) ||
                   (CHECK_ALIGN && is_misaligned(bus.req_funct3, bus.req_addr[1:0]));

    lsu_lane_align u_align (
        .rdata_i      (bus.mem_rdata),
        .lane_i       (addr_q[1:0]),
        .funct3_i     (funct3_q),
        .new_i        (wdata_q[15:0]),
        .load_data_o  (w_load),
        .merge_data_o (w_merge)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            funct3_q <= 3'b000;
            we_q     <= 1'b0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q   <= bus.req_addr;
                        funct3_q <= bus.req_funct3;
                        we_q     <= bus.req_we;
                        wdata_q  <= bus.req_wdata;
                        rdata_q  <= 32'h0;
                        err_q    <= err_d;
                        if (err_d)
                            state_q <= RESP;
                        else if (!bus.req_we)
                            state_q <= RD;
                        else if (bus.req_funct3 == F3_W)
                            state_q <= WR;
                        else
                            state_q <= RMW_RD;
                    end
                end
                RD:      state_q <= RD_CAP;
                RD_CAP: begin
                    rdata_q <= we_q ? 32'h0 : w_load;
                    state_q <= RESP;
                end
                RMW_RD:  state_q <= RMW_MRG;
                RMW_MRG: begin
                    wdata_q <= w_merge;
                    state_q <= WR;
                end
                WR:      state_q <= RESP;
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // All handshake and strobe outputs are pure decodes of the state register.
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_err   = err_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_load   = (state_q == RD) || (state_q == RMW_RD);
    assign bus.mem_store  = (state_q == WR);
    assign bus.mem_addr   = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu_ctrl
// Purpose  : Directed table-driven bench for dmem_lsu_ctrl with a word memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        mem_init;
    logic        t_valid, t_we;
    logic [2:0]  t_f3;
    logic [31:0] t_addr, t_wd;

    dmem_lsu_ctrl_if ifa ();
    dmem_lsu_ctrl_if ifb ();

    dmem_lsu_ctrl #(.CHECK_ALIGN(1'b1)) u_dut (.clk(clk), .rst(rst), .bus(ifa.slave));
    dmem_lsu_ctrl #(.CHECK_ALIGN(1'b0)) u_dut_na (.clk(clk), .rst(rst), .bus(ifb.slave));

    assign ifa.req_valid  = t_valid & ~sel;
    assign ifb.req_valid  = t_valid & sel;
    assign ifa.req_we     = t_we;
    assign ifb.req_we     = t_we;
    assign ifa.req_funct3 = t_f3;
    assign ifb.req_funct3 = t_f3;
    assign ifa.req_addr   = t_addr;
    assign ifb.req_addr   = t_addr;
    assign ifa.req_wdata  = t_wd;
    assign ifb.req_wdata  = t_wd;

    // Word memory models: sync read (zero when not loading), sync write.
    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];
    logic [31:0] rd_a, rd_b;
    always @(posedge clk) begin
        if (mem_init) begin
            mem_a[16] <= 32'h8899AABB;
            mem_b[16] <= 32'h8899AABB;
            rd_a      <= 32'h0;
            rd_b      <= 32'h0;
        end else begin
            if (ifa.mem_store) mem_a[ifa.mem_addr[7:2]] <= ifa.mem_wdata;
            if (ifb.mem_store) mem_b[ifb.mem_addr[7:2]] <= ifb.mem_wdata;
            rd_a <= ifa.mem_load ? mem_a[ifa.mem_addr[7:2]] : 32'h0;
            rd_b <= ifb.mem_load ? mem_b[ifb.mem_addr[7:2]] : 32'h0;
        end
    end
    assign ifa.mem_rdata = rd_a;
    assign ifb.mem_rdata = rd_b;

    logic        s_ready, s_rv, s_err, s_ld, s_st;
    logic [31:0] s_rd;
    assign s_ready = sel ? ifb.req_ready  : ifa.req_ready;
    assign s_rv    = sel ? ifb.resp_valid : ifa.resp_valid;
    assign s_err   = sel ? ifb.resp_err   : ifa.resp_err;
    assign s_ld    = sel ? ifb.mem_load   : ifa.mem_load;
    assign s_st    = sel ? ifb.mem_store  : ifa.mem_store;
    assign s_rd    = sel ? ifb.resp_rdata : ifa.resp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Cycle c of the masks is the c-th falling edge after the accept edge.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output logic err,
                           output int lat, output logic [7:0] ldm, output logic [7:0] stm,
                           output logic [7:0] rdym);
        rd = 32'h0; err = 1'b0; lat = 0; ldm = 8'h0; stm = 8'h0; rdym = 8'h0;
        @(negedge clk);
        t_we = we; t_f3 = f3; t_addr = a; t_wd = wd; t_valid = 1'b1;
        for (int c = 1; c <= 7 && lat == 0; c++) begin
            @(negedge clk);
            t_valid = 1'b0;
            ldm[c]  = s_ld;
            stm[c]  = s_st;
            rdym[c] = s_ready;
            if (s_rv) begin
                lat = c;
                rd  = s_rd;
                err = s_err;
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        logic [7:0]  exp_ld;
        logic [7:0]  exp_st;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [0:NV-1];

    task automatic apply(input string tag, input vec_t v);
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic [7:0]  ldm, stm, rdym;
        run_req(v.we, v.f3, v.addr, v.wd, rd, err, lat, ldm, stm, rdym);
        check({tag, " latency"}, lat, v.exp_lat);
        check({tag, " rdata"}, rd, v.exp_rd);
        check({tag, " err"}, {31'h0, err}, {31'h0, v.exp_err});
        check({tag, " load_cycles"}, {24'h0, ldm}, {24'h0, v.exp_ld});
        check({tag, " store_cycles"}, {24'h0, stm}, {24'h0, v.exp_st});
        check({tag, " ready_busy"}, {24'h0, rdym}, 32'h0);
        @(negedge clk);
        check({tag, " ready_after"}, {31'h0, s_ready}, 32'h1);
    endtask

    initial begin
        logic ok;
        vecs[0]  = '{1'b0, F3_W,   32'h40, 32'h0,        32'h8899AABB, 1'b0, 3, 8'h02, 8'h00};
        vecs[1]  = '{1'b0, F3_B,   32'h43, 32'h0,        32'hFFFFFF88, 1'b0, 3, 8'h02, 8'h00};
        vecs[2]  = '{1'b0, F3_BU,  32'h43, 32'h0,        32'h00000088, 1'b0, 3, 8'h02, 8'h00};
        vecs[3]  = '{1'b0, F3_H,   32'h40, 32'h0,        32'hFFFFAABB, 1'b0, 3, 8'h02, 8'h00};
        vecs[4]  = '{1'b0, F3_HU,  32'h42, 32'h0,        32'h00008899, 1'b0, 3, 8'h02, 8'h00};
        vecs[5]  = '{1'b0, F3_B,   32'h40, 32'h0,        32'hFFFFFFBB, 1'b0, 3, 8'h02, 8'h00};
        vecs[6]  = '{1'b1, F3_B,   32'h41, 32'h123456CC, 32'h0,        1'b0, 4, 8'h02, 8'h08};
        vecs[7]  = '{1'b0, F3_W,   32'h40, 32'h0,        32'h8899CCBB, 1'b0, 3, 8'h02, 8'h00};
        vecs[8]  = '{1'b1, F3_H,   32'h42, 32'h00001234, 32'h0,        1'b0, 4, 8'h02, 8'h08};
        vecs[9]  = '{1'b0, F3_W,   32'h40, 32'h0,        32'h1234CCBB, 1'b0, 3, 8'h02, 8'h00};
        vecs[10] = '{1'b1, F3_W,   32'h44, 32'hDEADBEEF, 32'h0,        1'b0, 2, 8'h00, 8'h02};
        vecs[11] = '{1'b0, F3_W,   32'h44, 32'h0,        32'hDEADBEEF, 1'b0, 3, 8'h02, 8'h00};
        vecs[12] = '{1'b0, F3_W,   32'h41, 32'h0,        32'h0,        1'b1, 1, 8'h00, 8'h00};
        vecs[13] = '{1'b0, 3'b011, 32'h40, 32'h0,        32'h0,        1'b1, 1, 8'h00, 8'h00};
        vecs[14] = '{1'b1, 3'b100, 32'h40, 32'h55,       32'h0,        1'b1, 1, 8'h00, 8'h00};
        vecs[15] = '{1'b0, F3_H,   32'h41, 32'h0,        32'h0,        1'b1, 1, 8'h00, 8'h00};
        vecs[16] = '{1'b0, F3_BU,  32'h41, 32'h0,        32'h000000CC, 1'b0, 3, 8'h02, 8'h00};
        vecs[17] = '{1'b0, F3_HU,  32'h40, 32'h0,        32'h0000CCBB, 1'b0, 3, 8'h02, 8'h00};
        vecs[18] = '{1'b1, F3_B,   32'h47, 32'h00000011, 32'h0,        1'b0, 4, 8'h02, 8'h08};

        sel = 1'b0; mem_init = 1'b1; rst = 1'b1;
        t_valid = 1'b0; t_we = 1'b0; t_f3 = 3'b000; t_addr = 32'h0; t_wd = 32'h0;

        // Reset state, with a request offered while reset is held.
        @(negedge clk);
        t_valid = 1'b1; t_we = 1'b0; t_f3 = F3_W; t_addr = 32'h40;
        @(negedge clk);
        @(negedge clk);
        check("rst ready", {31'h0, ifa.req_ready}, 32'h1);
        check("rst resp_valid", {31'h0, ifa.resp_valid}, 32'h0);
        check("rst resp_err", {31'h0, ifa.resp_err}, 32'h0);
        check("rst mem_load", {31'h0, ifa.mem_load}, 32'h0);
        check("rst mem_store", {31'h0, ifa.mem_store}, 32'h0);
        check("rst resp_rdata", ifa.resp_rdata, 32'h0);
        check("rst mem_addr", ifa.mem_addr, 32'h0);
        check("rst mem_wdata", ifa.mem_wdata, 32'h0);
        t_valid = 1'b0; mem_init = 1'b0; rst = 1'b0;

        for (int i = 0; i < NV; i++)
            apply($sformatf("v%0d", i), vecs[i]);
        check("mem word40", mem_a[16], 32'h1234CCBB);
        check("mem word44", mem_a[17], 32'h11ADBEEF);
        apply("lw44_after_sb", '{1'b0, F3_W, 32'h44, 32'h0, 32'h11ADBEEF, 1'b0, 3, 8'h02, 8'h00});

        // Reset while SB sits in RMW_MRG: no store, no response, memory intact.
        @(negedge clk);
        t_we = 1'b1; t_f3 = F3_B; t_addr = 32'h40; t_wd = 32'h000000EE; t_valid = 1'b1;
        @(negedge clk);
        t_valid = 1'b0;
        check("abort rmw_rd load", {31'h0, ifa.mem_load}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort ready in rst", {31'h0, ifa.req_ready}, 32'h1);
        ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b0;
            if (ifa.mem_store || ifa.resp_valid || !ifa.req_ready) ok = 1'b0;
        end
        check("abort quiet", {31'h0, ok}, 32'h1);
        check("abort word40", mem_a[16], 32'h1234CCBB);
        apply("lw40_after_abort", '{1'b0, F3_W, 32'h40, 32'h0, 32'h1234CCBB, 1'b0, 3, 8'h02, 8'h00});

        // Unchecked-alignment instance.
        sel = 1'b1;
        apply("na lw41", '{1'b0, F3_W, 32'h41, 32'h0, 32'h8899AABB, 1'b0, 3, 8'h02, 8'h00});
        apply("na lh43", '{1'b0, F3_H, 32'h43, 32'h0, 32'hFFFF8899, 1'b0, 3, 8'h02, 8'h00});
        apply("na sh43", '{1'b1, F3_H, 32'h43, 32'h5566, 32'h0,   1'b0, 4, 8'h02, 8'h08});
        apply("na lw40", '{1'b0, F3_W, 32'h40, 32'h0, 32'h5566AABB, 1'b0, 3, 8'h02, 8'h00});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
